scan_decoder: RTL
=================

// Module: scan_decoder
// PURPOSE
//  Registered, parametrised N-to-2^N decoder with active-low one-hot outputs and an active-low enable.
//  Adds three modes on top of plain decoding: direct decode, auto-scan and one-shot strobe.
//  Auto-scan steps through all outputs with a programmable dwell time.
//  One-shot strobes a single output for a programmable time.
//  Drives multiplexed display digits and keypad columns.
// PARAMETERS
//  SEL_W    3   select width; OUT_W = 1<<SEL_W outputs
//  DWELL_W  8   width of dwell counter; each index held dwell+1 cycles
// PORTS
//  clk      in   1        rising-edge clock
//  rst_n    in   1        asynchronous active-low reset
//  enb_     in   1        active-low enable; 1 forces all outputs high
//  mode     in   2        00 DIRECT, 01 SCAN, 10 ONESHOT, 11 reserved (treated as IDLE)
//  sel      in   SEL_W    decode index (DIRECT), scan start index (SCAN), strobe index (ONESHOT)
//  dwell    in   DWELL_W  cycles-1 per index in SCAN/ONESHOT
//  start    in   1        ONESHOT trigger, sampled high for one cycle
//  o        out  OUT_W    active-low one-hot; all 1s when idle/disabled
//  cur_idx  out  SEL_W    index currently driven low (0 when none)
//  busy     out  1        high while a ONESHOT strobe is active
//  wrap     out  1        one-cycle pulse when SCAN advances from OUT_W-1 to 0
// BEHAVIOUR
//  Reset (async, rst_n=0): o='1, cur_idx=0, busy=0, wrap=0, FSM=IDLE, dwell counter=0.
//  All outputs are registered. Latency from an input to o is 1 clock.
//  FSM states: IDLE, DIRECT, SCAN, SHOT.
//  enb_=1 has priority over everything:
//   - next cycle FSM=IDLE, o='1, busy=0, wrap=0 and counter cleared.
//   - cur_idx holds its last value.
//  enb_=0: the FSM follows mode every cycle.
//  A mode change aborts the current activity. The new mode takes effect on the next edge.
//  IDLE: o='1. Enters DIRECT/SCAN per mode.
//   - Enters SHOT only on start=1 with mode=ONESHOT.
//  DIRECT:
//   - o = ~(1<<sel) and cur_idx = sel, both registered.
//   - sel changes are tracked every cycle.
//  SCAN:
//   - Entry loads idx=sel and counter=0.
//   - While counter<dwell: counter increments and idx is held.
//   - When counter==dwell: counter=0 and idx=idx+1 modulo OUT_W.
//   - On the step from OUT_W-1 to 0, wrap=1 for that cycle.
//   - dwell=0 gives a step every cycle.
//   - dwell is sampled at each compare; a mid-scan change applies at the next compare.
//   - sel is ignored after entry.
//  SHOT:
//   - Entry latches idx=sel, sets busy=1 and drives o=~(1<<idx) for exactly dwell+1 cycles.
//   - Then o='1, busy=0 and the FSM returns to IDLE.
//   - start while busy is ignored; no queueing.
//   - start on the cycle busy falls is ignored. A new strobe needs start with busy=0 in IDLE.
//  In SHOT and SCAN, exactly one bit of o is low at all times.
//  mode=11 is treated as IDLE with o='1.
//  Counter arithmetic is unsigned DWELL_W bits. Index arithmetic is SEL_W bits with natural wrap.
// STRUCTURE
//  Package scan_decoder_pkg:
//   - mode encodings MODE_DIRECT/MODE_SCAN/MODE_ONESHOT
//   - FSM state enum
//  Sub-module onehot_n_dec (combinational, SEL_W in, active-low OUT_W out).
//   - Instantiated once, feeding the o register.
//  FSM, dwell counter and index register live in scan_decoder.
// TESTING
//  1. Reset, enb_=0, DIRECT, sel=5 -> next edge o=8'b1101_1111, cur_idx=5; sel=0 -> o=8'b1111_1110.
//  2. SCAN, sel=6, dwell=2 -> idx sequence 6,6,6,7,7,7,0..., wrap=1 only on the 7->0 cycle.
//  3. ONESHOT, sel=3, dwell=4, start pulse -> o=8'b1111_0111 for exactly 5 cycles, busy matches.
//     A second start mid-strobe is ignored.
//  4. Mid-SCAN enb_=1 -> next cycle o=8'hFF, busy=0.
//     Then enb_=0 with SCAN -> restarts at the current sel.
//  5. rst_n low mid-ONESHOT (asynchronous, between edges) -> o=8'hFF and busy=0 immediately.
//     Release -> IDLE.
//  6. mode=11 -> o=8'hFF. SEL_W=4 build: SCAN dwell=0 covers 16 outputs, wrap every 16 cycles.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared mode encodings and FSM state type for the scan decoder.
package scan_decoder_pkg;

    localparam logic [1:0] MODE_DIRECT  = 2'b00;
    localparam logic [1:0] MODE_SCAN    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan,
        StShot
    } state_e;

endpackage

// File: rtl/onehot_n_dec.sv
// Combinational SEL_W-to-2^SEL_W decoder with active-low one-hot output.
module onehot_n_dec #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned OUT_W = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dec_n
);

    always_comb begin
        dec_n      = '1;
        dec_n[sel] = 1'b0;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered active-low decoder with direct, auto-scan and one-shot strobe modes.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned OUT_W   = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enb_,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               start,
    output logic [OUT_W-1:0]   o,
    output logic [SEL_W-1:0]   cur_idx,
    output logic               busy,
    output logic               wrap
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   o_q, o_d;
    logic [SEL_W-1:0]   cur_idx_q, cur_idx_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic               show;
    logic [OUT_W-1:0]   dec_n;

    onehot_n_dec #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_dec (
        .sel   (idx_d),
        .dec_n (dec_n)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        o_d       = '1;
        cur_idx_d = cur_idx_q;
        busy_d    = 1'b0;
        wrap_d    = 1'b0;
        show      = 1'b0;

        if (enb_) begin
            // Disable keeps cur_idx so software can see where activity stopped.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (mode)
                MODE_DIRECT: begin
                    state_d = StDirect;
                    idx_d   = sel;
                    cnt_d   = '0;
                    show    = 1'b1;
                end
                MODE_SCAN: begin
                    state_d = StScan;
                    show    = 1'b1;
                    if (state_q != StScan) begin
                        idx_d = sel;
                        cnt_d = '0;
                    end else if (cnt_q >= dwell) begin
                        cnt_d  = '0;
                        idx_d  = idx_q + SEL_W'(1);
                        wrap_d = &idx_q;
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
                MODE_ONESHOT: begin
                    if (state_q == StShot) begin
                        if (cnt_q >= dwell) begin
                            state_d   = StIdle;
                            cnt_d     = '0;
                            cur_idx_d = '0;
                        end else begin
                            cnt_d  = cnt_q + DWELL_W'(1);
                            busy_d = 1'b1;
                            show   = 1'b1;
                        end
                    end else if (state_q == StIdle && start && !busy_q) begin
                        state_d = StShot;
                        idx_d   = sel;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        show    = 1'b1;
                    end else begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        cur_idx_d = '0;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    cur_idx_d = '0;
                end
            endcase
        end

        if (show) begin
            o_d       = dec_n;
            cur_idx_d = idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            o_q       <= '1;
            cur_idx_q <= '0;
            busy_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            cur_idx_q <= cur_idx_d;
            busy_q    <= busy_d;
            wrap_q    <= wrap_d;
        end
    end

    assign o       = o_q;
    assign cur_idx = cur_idx_q;
    assign busy    = busy_q;
    assign wrap    = wrap_q;

endmodule
